// File: rtl/crc_dec_pkg.sv
// Shared types for the CRC decelerator host sequencer: command codes, FSM states and
// the default maximum CRC width.
package crc_dec_pkg;

    localparam int unsigned BITWIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        CmdReset   = 2'd0,
        CmdSetup   = 2'd1,
        CmdMessage = 2'd2,
        CmdFinal   = 2'd3
    } dut_cmd_e;

    typedef enum logic [3:0] {
        StIdle,
        StSetup,
        StSetupRel,
        StMsgLead,
        StMsgLo,
        StMsgHi,
        StMsgShift,
        StMsgStall,
        StFinIdx,
        StFinDrain,
        StDone
    } state_e;

    function automatic logic [4:0] clamp_count(logic [4:0] value, logic [4:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/crc_readback_assembler.sv
// Captures decelerator readback bytes two cycles after each index is issued and
// assembles them into the zero-extended CRC result.
module crc_readback_assembler
    import crc_dec_pkg::*;
#(
    parameter int unsigned BITWIDTH = BITWIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                idx_valid,
    input  logic [2:0]          idx,
    input  logic [7:0]          rdata,
    output logic [BITWIDTH-1:0] crc_value
);

    localparam int unsigned NBytes = BITWIDTH / 8;
    localparam int unsigned NSlots = (NBytes > 8) ? 8 : NBytes;

    logic [1:0]          vld_q;
    logic [2:0]          idx1_q;
    logic [2:0]          idx2_q;
    logic [BITWIDTH-1:0] crc_q;

    // Two-stage index pipeline matches the decelerator's readback latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 2'b00;
            idx1_q <= 3'd0;
            idx2_q <= 3'd0;
            crc_q  <= '0;
        end else begin
            vld_q  <= {vld_q[0], idx_valid};
            idx1_q <= idx;
            idx2_q <= idx1_q;
            if (clear) begin
                crc_q <= '0;
            end else if (vld_q[1]) begin
                for (int i = 0; i < NSlots; i++) begin
                    if (idx2_q == 3'(i)) begin
                        crc_q[8*i +: 8] <= rdata;
                    end
                end
            end
        end
    end

    assign crc_value = crc_q;

endmodule

// File: rtl/crc_host_sequencer.sv
// Host-side sequencer: streams CRC configuration and message nibbles into the decelerator,
// then reads the result back one byte at a time.
module crc_host_sequencer
    import crc_dec_pkg::*;
#(
    parameter int unsigned BITWIDTH = BITWIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                setup_start,
    input  logic [5:0]          cfg_width,
    input  logic                cfg_reflect_in,
    input  logic                cfg_reflect_out,
    input  logic [BITWIDTH-1:0] cfg_poly,
    input  logic [BITWIDTH-1:0] cfg_init,
    input  logic [BITWIDTH-1:0] cfg_xor,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    input  logic                byte_last,
    output logic                byte_ready,
    output logic [1:0]          dut_cmd,
    output logic [3:0]          dut_data,
    input  logic [7:0]          dut_rdata,
    output logic                crc_valid,
    output logic [BITWIDTH-1:0] crc_value,
    output logic                busy
);

    // Nibble and byte counts never exceed what a 6-bit width field can express.
    localparam int unsigned NMaxInt = (BITWIDTH / 4 > 16) ? 16 : BITWIDTH / 4;
    localparam int unsigned BMaxInt = (BITWIDTH / 8 > 8) ? 8 : BITWIDTH / 8;
    localparam logic [4:0]  NMax    = 5'(NMaxInt);
    localparam logic [4:0]  BMax    = 5'(BMaxInt);

    state_e              state_q, state_d;
    dut_cmd_e            cmd;
    logic [5:0]          cnt_q, cnt_d;
    logic [4:0]          width_q;
    logic                refl_in_q, refl_out_q;
    logic [BITWIDTH-1:0] poly_q, init_q, xor_q;
    logic [4:0]          n_q;
    logic [3:0]          b_q;
    logic [3:0]          byte_hi_q;
    logic                last_q;
    logic                start;
    logic                accept;
    logic                rb_valid;
    logic [4:0]          n_raw, b_raw, b_clamped;
    logic [5:0]          n_ext;
    logic [5:0]          setup_last;
    logic [3:0]          setup_nibble;

    function automatic logic [3:0] nibble_at(logic [BITWIDTH-1:0] vec, logic [5:0] idx);
        logic [BITWIDTH-1:0] shifted;
        shifted = vec >> {idx, 2'b00};
        return shifted[3:0];
    endfunction

    assign start      = (state_q == StIdle) && setup_start;
    assign accept     = byte_valid && byte_ready;
    assign n_raw      = {1'b0, cfg_width[5:2]} + 5'd1;
    assign b_raw      = {2'b00, cfg_width[5:3]} + 5'd1;
    assign b_clamped  = clamp_count(b_raw, BMax);
    assign n_ext      = {1'b0, n_q};
    assign setup_last = 6'd3 * n_ext + 6'd2;
    assign busy       = (state_q != StIdle);
    assign dut_cmd    = cmd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_q    <= '0;
            refl_in_q  <= 1'b0;
            refl_out_q <= 1'b0;
            poly_q     <= '0;
            init_q     <= '0;
            xor_q      <= '0;
            n_q        <= '0;
            b_q        <= '0;
        end else if (start) begin
            width_q    <= cfg_width[4:0];
            refl_in_q  <= cfg_reflect_in;
            refl_out_q <= cfg_reflect_out;
            poly_q     <= cfg_poly;
            init_q     <= cfg_init;
            xor_q      <= cfg_xor;
            n_q        <= clamp_count(n_raw, NMax);
            b_q        <= b_clamped[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_hi_q <= '0;
            last_q    <= 1'b0;
        end else if (start) begin
            last_q    <= 1'b0;
        end else if (accept) begin
            byte_hi_q <= byte_data[7:4];
            last_q    <= byte_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Setup stream: config_lo, config_hi, poly, init, xor (LS nibble first), trailing zero.
    always_comb begin
        setup_nibble = 4'd0;
        if (cnt_q == 6'd0) begin
            setup_nibble = width_q[3:0];
        end else if (cnt_q == 6'd1) begin
            setup_nibble = {1'b0, width_q[4], refl_out_q, refl_in_q};
        end else if (cnt_q < n_ext + 6'd2) begin
            setup_nibble = nibble_at(poly_q, cnt_q - 6'd2);
        end else if (cnt_q < 6'd2 * n_ext + 6'd2) begin
            setup_nibble = nibble_at(init_q, cnt_q - n_ext - 6'd2);
        end else if (cnt_q < setup_last) begin
            setup_nibble = nibble_at(xor_q, cnt_q - 6'd2 * n_ext - 6'd2);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd        = CmdReset;
        dut_data   = 4'd0;
        byte_ready = 1'b0;
        crc_valid  = 1'b0;
        rb_valid   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (setup_start) begin
                    state_d = StSetup;
                    cnt_d   = '0;
                end
            end
            StSetup: begin
                cmd      = CmdSetup;
                dut_data = setup_nibble;
                if (cnt_q == setup_last) begin
                    state_d = StSetupRel;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            StSetupRel: begin
                cmd     = CmdFinal;
                state_d = byte_valid ? StMsgLead : StMsgStall;
            end
            StMsgLead: begin
                cmd     = CmdMessage;
                state_d = StMsgLo;
            end
            StMsgLo: begin
                cmd        = CmdMessage;
                dut_data   = byte_data[3:0];
                byte_ready = 1'b1;
                state_d    = StMsgHi;
            end
            StMsgHi: begin
                cmd      = CmdMessage;
                dut_data = byte_hi_q;
                state_d  = StMsgShift;
                cnt_d    = '0;
            end
            StMsgShift: begin
                cmd = CmdMessage;
                if (cnt_q == 6'd7) begin
                    cnt_d = '0;
                    if (last_q) begin
                        state_d = StFinIdx;
                    end else if (byte_valid) begin
                        state_d = StMsgLo;
                    end else begin
                        state_d = StMsgStall;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            StMsgStall: begin
                // FINAL rather than RESET keeps the decelerator's accumulator intact.
                cmd = CmdFinal;
                if (byte_valid) begin
                    state_d = StMsgLead;
                end
            end
            StFinIdx: begin
                cmd      = CmdFinal;
                dut_data = cnt_q[3:0];
                rb_valid = 1'b1;
                if (cnt_q[3:0] == b_q - 4'd1) begin
                    state_d = StFinDrain;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            StFinDrain: begin
                cmd      = CmdFinal;
                dut_data = b_q - 4'd1;
                if (cnt_q == 6'd1) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            StDone: begin
                crc_valid = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    crc_readback_assembler #(
        .BITWIDTH (BITWIDTH)
    ) u_readback (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start),
        .idx_valid (rb_valid),
        .idx       (cnt_q[2:0]),
        .rdata     (dut_rdata),
        .crc_value (crc_value)
    );

endmodule
